// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sccb_pkg
// Brief    : Shared types and constants for the SCCB slave responder.
// Revision : 1.0 - initial release
// ============================================================================
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_DEVID  = 4'd1,
    ST_ACK_ID = 4'd2,
    ST_ADDR_H = 4'd3,
    ST_ACK_AH = 4'd4,
    ST_ADDR_L = 4'd5,
    ST_ACK_AL = 4'd6,
    ST_WDATA  = 4'd7,
    ST_ACK_WD = 4'd8,
    ST_RDATA  = 4'd9,
    ST_MACK   = 4'd10,
    ST_IGNORE = 4'd11
  } sccb_state_e;

  localparam logic [6:0] SCCB_DEV_ID = 7'h3C;
  localparam logic       SCCB_WR_BIT = 1'b0;
  localparam logic       SCCB_RD_BIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sccb_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : sccb_line_sync
// Brief    : SCL/SDA synchronizers with registered edge, START and STOP events.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_line_sync (
  input  logic clk,
  input  logic rstn,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);

  logic r_scl_meta, r_scl_sync, r_scl_hist;
  logic r_sda_meta, r_sda_sync, r_sda_hist;
  logic r_scl_rise, r_scl_fall, r_start, r_stop;
  logic w_scl_steady_hi;

  // An SCL change in the same sample as an SDA change makes this false,
  // so such a sample is treated as a data bit rather than START/STOP.
  assign w_scl_steady_hi = r_scl_sync & r_scl_hist;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_hist <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_hist <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_meta <= i_scl;
      r_scl_sync <= r_scl_meta;
      r_scl_hist <= r_scl_sync;
      r_sda_meta <= i_sda;
      r_sda_sync <= r_sda_meta;
      r_sda_hist <= r_sda_sync;
      r_scl_rise <= r_scl_sync & ~r_scl_hist;
      r_scl_fall <= ~r_scl_sync & r_scl_hist;
      r_start    <= w_scl_steady_hi & ~r_sda_sync & r_sda_hist;
      r_stop     <= w_scl_steady_hi & r_sda_sync & ~r_sda_hist;
    end
  end

  assign o_scl_rise = r_scl_rise;
  assign o_scl_fall = r_scl_fall;
  assign o_start    = r_start;
  assign o_stop     = r_stop;
  assign o_sda      = r_sda_hist;

endmodule
`default_nettype wire

// File: rtl/sccb_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : sccb_slave_responder
// Brief    : SCCB slave with 16-bit register addressing and an 8-bit register file.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_slave_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ID = SCCB_DEV_ID,
  parameter int unsigned MEM_AW = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        busy,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);

  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

  logic w_rise, w_fall, w_start, w_stop, w_sda;
  sccb_state_e r_state, w_state_nxt;

  logic [2:0]  r_cnt;
  logic [6:0]  r_shift;
  logic [7:0]  r_addr_h;
  logic [15:0] r_ptr;
  logic [7:0]  r_rdbuf;
  logic        r_rw, r_ackd, r_sda_oe, r_busy, r_wr_valid;
  logic [15:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic [MEM_DEPTH-1:0][7:0] r_mem;

  logic [7:0]  w_byte;
  logic        w_last, w_id_match, w_ack_st;
  logic [15:0] w_ptr_inc;
  logic [2:0]  w_rd_idx;

  sccb_line_sync u_line_sync (
    .clk        (clk),
    .rstn       (rstn),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_sda      (w_sda)
  );

  assign w_byte     = {r_shift, w_sda};
  assign w_last     = (r_cnt == 3'd7);
  assign w_id_match = (w_byte[7:1] == DEV_ID);
  assign w_ptr_inc  = r_ptr + 16'd1;
  assign w_rd_idx   = 3'd7 - r_cnt;
  assign w_ack_st   = (r_state == ST_ACK_ID) || (r_state == ST_ACK_AH) ||
                      (r_state == ST_ACK_AL) || (r_state == ST_ACK_WD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Byte states advance on the 8th SCL rise; ACK states leave on their second SCL fall.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_DEVID;
    end else begin
      case (r_state)
        ST_DEVID:  if (w_rise && w_last) w_state_nxt = w_id_match ? ST_ACK_ID : ST_IGNORE;
        ST_ACK_ID: if (w_fall && r_ackd) w_state_nxt = (r_rw == SCCB_RD_BIT) ? ST_RDATA : ST_ADDR_H;
        ST_ADDR_H: if (w_rise && w_last) w_state_nxt = ST_ACK_AH;
        ST_ACK_AH: if (w_fall && r_ackd) w_state_nxt = ST_ADDR_L;
        ST_ADDR_L: if (w_rise && w_last) w_state_nxt = ST_ACK_AL;
        ST_ACK_AL: if (w_fall && r_ackd) w_state_nxt = ST_WDATA;
        ST_WDATA:  if (w_rise && w_last) w_state_nxt = ST_ACK_WD;
        ST_ACK_WD: if (w_fall && r_ackd) w_state_nxt = ST_WDATA;
        ST_RDATA:  if (w_rise && w_last) w_state_nxt = ST_MACK;
        ST_MACK:   if (w_rise) w_state_nxt = w_sda ? ST_IGNORE : ST_RDATA;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_addr_h   <= '0;
      r_ptr      <= '0;
      r_rdbuf    <= '0;
      r_rw       <= 1'b0;
      r_ackd     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_mem      <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_stop) begin
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
        r_cnt    <= '0;
        r_ackd   <= 1'b0;
      end else if (w_start) begin
        r_sda_oe <= 1'b0;
        r_cnt    <= '0;
        r_ackd   <= 1'b0;
      end else if (w_rise) begin
        case (r_state)
          ST_DEVID, ST_ADDR_H, ST_ADDR_L, ST_WDATA: begin
            r_shift <= w_byte[6:0];
            r_cnt   <= r_cnt + 3'd1;
            if (w_last) begin
              if (r_state == ST_DEVID) begin
                r_rw   <= w_sda;
                r_busy <= w_id_match;
                if (w_sda == SCCB_RD_BIT) r_rdbuf <= r_mem[r_ptr[MEM_AW-1:0]];
              end
              if (r_state == ST_ADDR_H) r_addr_h <= w_byte;
              if (r_state == ST_ADDR_L) r_ptr <= {r_addr_h, w_byte};
              if (r_state == ST_WDATA) begin
                r_mem[r_ptr[MEM_AW-1:0]] <= w_byte;
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_ptr;
                r_wr_data  <= w_byte;
                r_ptr      <= w_ptr_inc;
              end
            end
          end
          ST_RDATA: r_cnt <= r_cnt + 3'd1;
          ST_MACK: begin
            if (!w_sda) begin
              r_ptr   <= w_ptr_inc;
              r_rdbuf <= r_mem[w_ptr_inc[MEM_AW-1:0]];
              r_cnt   <= '0;
            end
          end
          default: ;
        endcase
      end else if (w_fall) begin
        if (w_ack_st) begin
          if (!r_ackd) begin
            r_sda_oe <= 1'b1;
            r_ackd   <= 1'b1;
          end else begin
            // The fall that ends the ID ACK of a read also launches data bit 7.
            r_ackd   <= 1'b0;
            r_sda_oe <= (r_state == ST_ACK_ID && r_rw == SCCB_RD_BIT) ? ~r_rdbuf[7] : 1'b0;
          end
        end else if (r_state == ST_RDATA) begin
          r_sda_oe <= ~r_rdbuf[w_rd_idx];
        end else begin
          r_sda_oe <= 1'b0;
        end
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_sccb_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccb_slave_responder
// Brief    : Directed bit-banged SCCB master exercising the slave responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sccb_slave_responder;
  import sccb_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, scl_m, sda_m;
  logic        sda_line;
  logic        sda_oe, busy, wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int checks = 0;
  int errors = 0;
  int commits = 0;
  int oe_cycles = 0;
  int busy_cycles = 0;
  logic [15:0] addr_log [16];
  logic [7:0]  data_log [16];

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  sccb_slave_responder dut (
    .clk      (clk),
    .rstn     (rstn),
    .scl_in   (scl_m),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      addr_log[commits[3:0]] <= wr_addr;
      data_log[commits[3:0]] <= wr_data;
      commits <= commits + 1;
    end
    if (sda_oe) oe_cycles <= oe_cycles + 1;
    if (busy)   busy_cycles <= busy_cycles + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wclk(4);
    scl_m = 1'b1; wclk(6);
    sda_m = 1'b0; wclk(6);
    scl_m = 1'b0; wclk(2);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wclk(6);
    scl_m = 1'b1; wclk(6);
    sda_m = 1'b1; wclk(6);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wclk(6);
    scl_m = 1'b1; wclk(8);
    scl_m = 1'b0; wclk(2);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wclk(6);
    scl_m = 1'b1; wclk(4);
    b = sda_line; wclk(4);
    scl_m = 1'b0; wclk(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(s);
      d[i] = s;
    end
    send_bit(mack ? 1'b0 : 1'b1);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int base_c, base_oe, base_busy;

    rstn = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    wclk(4);
    check("rst_sda_oe",   sda_oe,   0);
    check("rst_busy",     busy,     0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr",  wr_addr,  0);
    check("rst_wr_data",  wr_data,  0);
    check("rst_state",    dut.r_state, ST_IDLE);
    rstn = 1'b1;
    wclk(5);

    // Single write 78/30/08/A5
    base_c = commits;
    bus_start();
    send_byte(8'h78, ack); check("wr_ack_id", ack, 1);
    send_byte(8'h30, ack); check("wr_ack_ah", ack, 1);
    send_byte(8'h08, ack); check("wr_ack_al", ack, 1);
    check("wr_busy_mid", busy, 1);
    send_byte(8'hA5, ack); check("wr_ack_wd", ack, 1);
    bus_stop();
    wclk(2);
    check("wr_commits", commits - base_c, 1);
    check("wr_addr_log", addr_log[base_c[3:0]], 16'h3008);
    check("wr_data_log", data_log[base_c[3:0]], 8'hA5);
    check("wr_mem08", dut.r_mem[8'h08], 8'hA5);
    check("wr_busy_end", busy, 0);

    // Pointer set, then read back
    bus_start();
    send_byte(8'h78, ack); check("rd_ack_id", ack, 1);
    send_byte(8'h30, ack); check("rd_ack_ah", ack, 1);
    send_byte(8'h08, ack); check("rd_ack_al", ack, 1);
    bus_stop();
    bus_start();
    send_byte(8'h79, ack); check("rd_ack_rid", ack, 1);
    check("rd_busy", busy, 1);
    recv_byte(1'b0, rd);
    check("rd_data", rd, 8'hA5);
    bus_stop();
    wclk(2);
    check("rd_busy_end", busy, 0);
    check("rd_oe_end", sda_oe, 0);

    // Burst across the 16-bit wrap
    base_c = commits;
    bus_start();
    send_byte(8'h78, ack);
    send_byte(8'hFF, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack); check("wrap_ack1", ack, 1);
    send_byte(8'h22, ack); check("wrap_ack2", ack, 1);
    bus_stop();
    wclk(2);
    check("wrap_commits", commits - base_c, 2);
    check("wrap_addr0", addr_log[base_c[3:0]], 16'hFFFF);
    check("wrap_data0", data_log[base_c[3:0]], 8'h11);
    check("wrap_addr1", addr_log[4'(base_c + 1)], 16'h0000);
    check("wrap_data1", data_log[4'(base_c + 1)], 8'h22);
    check("wrap_memFF", dut.r_mem[8'hFF], 8'h11);
    check("wrap_mem00", dut.r_mem[8'h00], 8'h22);

    // Wrong device ID
    base_c = commits; base_oe = oe_cycles; base_busy = busy_cycles;
    bus_start();
    send_byte(8'h7A, ack); check("wid_ack_id", ack, 0);
    send_byte(8'h30, ack); check("wid_ack_b1", ack, 0);
    send_byte(8'h08, ack);
    send_byte(8'h55, ack); check("wid_ack_b3", ack, 0);
    bus_stop();
    wclk(2);
    check("wid_oe_cycles",   oe_cycles - base_oe, 0);
    check("wid_busy_cycles", busy_cycles - base_busy, 0);
    check("wid_commits",     commits - base_c, 0);

    // Write interrupted by repeated START after 4 data bits
    base_c = commits;
    bus_start();
    send_byte(8'h78, ack);
    send_byte(8'h30, ack);
    send_byte(8'h08, ack);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus_start();
    send_byte(8'h79, ack); check("int_ack_rid", ack, 1);
    recv_byte(1'b0, rd);
    check("int_rd_data", rd, 8'hA5);
    bus_stop();
    wclk(2);
    check("int_commits", commits - base_c, 0);
    check("int_mem08", dut.r_mem[8'h08], 8'hA5);

    // Reset during RDATA while the slave pulls SDA low (bit 6 of A5 is 0)
    bus_start();
    send_byte(8'h78, ack);
    send_byte(8'h30, ack);
    send_byte(8'h08, ack);
    bus_stop();
    bus_start();
    send_byte(8'h79, ack);
    recv_bit(rd[7]);
    check("rst_rd_bit7", rd[7], 1);
    wclk(4);
    check("rst_pre_oe", sda_oe, 1);
    rstn = 1'b0;
    #1;
    check("rst_async_oe", sda_oe, 0);
    check("rst_async_state", dut.r_state, ST_IDLE);
    check("rst_async_mem08", dut.r_mem[8'h08], 8'h00);
    check("rst_async_busy", busy, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    wclk(3);
    rstn = 1'b1;
    wclk(5);
    bus_start();
    send_byte(8'h78, ack); check("post_rst_ack", ack, 1);
    send_byte(8'h00, ack);
    send_byte(8'h08, ack);
    bus_stop();
    bus_start();
    send_byte(8'h79, ack);
    recv_byte(1'b0, rd);
    check("post_rst_rd", rd, 8'h00);
    bus_stop();
    wclk(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
